lin_deslin_ctrl_n: RTL and testbench
====================================

LIN_DESLIN_CTRL_N -- requirements
Module: lin_deslin_ctrl_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sample/coefficient width in bits.
REQ-002 SHALL have parameter CHANNELS, default 2, channels per frame (range 1..16).
REQ-003 SHALL have parameter FRAC, default 16, fractional bits of signed Q format (range 1..WIDTH-2).
REQ-004 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  frame offered.
REQ-007 SHALL have port in_ready  output  1  block can accept a frame.
REQ-008 SHALL have port in_data  input  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH], signed.
REQ-009 SHALL have port mode  input  1  0 = linearize, 1 = delinearize.
REQ-010 SHALL have port gain, offset, inv_gain  input  WIDTH each  signed Q coefficients.
REQ-011 SHALL have port out_valid  output  1  result frame available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port out_data  output  CHANNELS*WIDTH  results, same packing as in_data.
REQ-014 SHALL have port sat  output  1  at least one channel of the frame saturated.

Function
REQ-015 SHALL implement FSM states IDLE, PRE, MUL, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept on in_valid & in_ready in IDLE, capturing in_data, mode, gain, offset, inv_gain; later input changes ignored until next accept.
REQ-017 SHALL process channels sequentially 0..CHANNELS-1, one PRE then one MUL cycle each, via a single shared multiplier and a channel counter.
REQ-018 SHALL, linearize: y = sat(((x * gain) >>> FRAC) + offset); delinearize: y = sat(((x - offset) * inv_gain) >>> FRAC).
REQ-019 SHALL compute the subtraction in WIDTH+1 bits, the product in full 2*WIDTH+2 bits, with no intermediate wrap.
REQ-020 SHALL saturate to signed max 0x7F..F / min 0x80..0; sat is the OR over all channels of the frame.
REQ-021 SHALL enter DONE after MUL of the last channel; out_valid = 1 exactly in DONE; first cycle of out_valid is 2*CHANNELS+1 cycles after the accept cycle.
REQ-022 SHALL hold out_data and sat stable while out_valid & !out_ready, indefinitely.
REQ-023 SHALL return DONE -> IDLE on out_ready; no accept in that same cycle (throughput one frame per 2*CHANNELS+2 cycles).
REQ-024 SHALL keep out_data/sat of the last frame unchanged until the next frame's DONE.

Reset
REQ-025 SHALL, on reset high at a clock edge, force IDLE, channel counter 0, out_valid 0, out_data 0, sat 0, in_ready 1 in the following cycle.
REQ-026 SHALL give reset priority over any handshake; a frame in progress is discarded with no partial output.

Configuration
REQ-027 SHALL, with LIN_DESLIN_ROUND_EN defined, add 2^(FRAC-1) to the product before the shift (round half up).
REQ-028 SHALL, without LIN_DESLIN_ROUND_EN, truncate toward negative infinity (plain arithmetic shift).

Verification (WIDTH=32, FRAC=16, CHANNELS=2)
REQ-029 SHALL cover: linearize x=0x0002_0000, gain=0x0001_8000, offset=0x0000_8000 -> 0x0003_8000, sat=0, out_valid 5 cycles after accept.
REQ-030 SHALL cover: delinearize x=0x0003_8000, offset=0x0000_8000, inv_gain=0x0000_8000 -> 0x0001_8000.
REQ-031 SHALL cover: linearize x=0x7FFF_0000, gain=0x0002_0000, offset=0 -> 0x7FFF_FFFF, sat=1; other channel x=0x8000_0000 -> 0x8000_0000.
REQ-032 SHALL cover: x=0x0000_0001, gain=0x0000_8000, offset=0 -> 0x0000_0000 without macro, 0x0000_0001 with LIN_DESLIN_ROUND_EN; x=0xFFFF_0000, gain=0x0000_0001 -> 0xFFFF_FFFF without macro.
REQ-033 SHALL cover: out_ready held low 10 cycles in DONE -> out_valid, out_data, sat stable, in_ready 0, in_valid ignored.
REQ-034 SHALL cover: reset pulsed during MUL of channel 1 -> next cycle IDLE, out_valid 0, out_data 0; subsequent frame processed correctly.

Source files
------------

// File: rtl/lin_deslin_ctrl_n.sv
// rtl/lin_deslin_ctrl_n.sv - per-channel Q-format linearize/delinearize engine sharing one multiplier
// Optional: define LIN_DESLIN_ROUND_EN for round-half-up before the fractional shift (default truncates).
module lin_deslin_ctrl_n #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int FRAC     = 16
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          gain,
  input  logic [WIDTH-1:0]          offset,
  input  logic [WIDTH-1:0]          inv_gain,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      sat
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = 2*WIDTH + 2;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PRE  = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic signed [PW-1:0] MAXV = {{(WIDTH+3){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(WIDTH+3){1'b1}}, {(WIDTH-1){1'b0}}};
`ifdef LIN_DESLIN_ROUND_EN
  localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC-1);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  logic [1:0]                state;
  logic [CW-1:0]             ch;
  logic [CHANNELS*WIDTH-1:0] in_r;
  logic                      mode_r;
  logic [WIDTH-1:0]          gain_r, off_r, igain_r;
  logic signed [WIDTH:0]     op_a;
  logic signed [WIDTH-1:0]   op_b;
  logic [CHANNELS*WIDTH-1:0] res_work, res_next;
  logic                      sat_work;

  logic [WIDTH-1:0]          x;
  logic signed [WIDTH:0]     x_ext, off_ext;
  logic signed [PW-1:0]      prod, shifted, sum;
  logic [WIDTH-1:0]          y;
  logic                      y_sat;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    x       = in_r[ch*WIDTH +: WIDTH];
    x_ext   = {x[WIDTH-1], x};
    off_ext = {off_r[WIDTH-1], off_r};
    prod    = op_a * op_b;
    shifted = (prod + RND) >>> FRAC;
    // offset is added after the shift only when linearizing
    sum     = mode_r ? shifted : shifted + PW'(off_ext);
    y_sat   = 1'b0;
    y       = sum[WIDTH-1:0];
    if (sum > MAXV) begin
      y     = {1'b0, {(WIDTH-1){1'b1}}};
      y_sat = 1'b1;
    end else if (sum < MINV) begin
      y     = {1'b1, {(WIDTH-1){1'b0}}};
      y_sat = 1'b1;
    end
    res_next                    = res_work;
    res_next[ch*WIDTH +: WIDTH] = y;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= IDLE;
      ch       <= '0;
      out_data <= '0;
      sat      <= 1'b0;
      sat_work <= 1'b0;
      res_work <= '0;
      in_r     <= '0;
      mode_r   <= 1'b0;
      gain_r   <= '0;
      off_r    <= '0;
      igain_r  <= '0;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_r     <= in_data;
          mode_r   <= mode;
          gain_r   <= gain;
          off_r    <= offset;
          igain_r  <= inv_gain;
          ch       <= '0;
          sat_work <= 1'b0;
          state    <= PRE;
        end
        PRE: begin
          op_a  <= mode_r ? (x_ext - off_ext) : x_ext;
          op_b  <= mode_r ? igain_r : gain_r;
          state <= MUL;
        end
        MUL: begin
          res_work <= res_next;
          sat_work <= sat_work | y_sat;
          // results become visible only when the whole frame is finished
          if (ch == LAST_CH) begin
            out_data <= res_next;
            sat      <= sat_work | y_sat;
            state    <= DONE;
          end else begin
            ch    <= ch + 1'b1;
            state <= PRE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lin_deslin_ctrl_n.sv
// tb/tb_lin_deslin_ctrl_n.sv - scoreboard bench for lin_deslin_ctrl_n (WIDTH=32, CHANNELS=2, FRAC=16)
module tb_lin_deslin_ctrl_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        mode;
  logic [31:0] gain, offset, inv_gain;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        sat;

  typedef struct {
    logic [63:0] d;
    logic        s;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  lin_deslin_ctrl_n #(.WIDTH(32), .CHANNELS(2), .FRAC(16)) dut (
    .CLK(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .gain(gain), .offset(offset),
    .inv_gain(inv_gain), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat(sat)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [31:0] model(input logic m, input logic [31:0] x, input logic [31:0] g,
                                        input logic [31:0] o, input logic [31:0] ig, output logic s);
    logic signed [127:0] xs, gs, os, igs, p, r;
    xs = $signed(x); gs = $signed(g); os = $signed(o); igs = $signed(ig);
    p = m ? (xs - os) * igs : xs * gs;
`ifdef LIN_DESLIN_ROUND_EN
    p = p + 128'sd32768;
`endif
    r = p >>> 16;
    if (!m) r = r + os;
    s = 1'b1;
    if (r > 128'sd2147483647) return 32'h7FFF_FFFF;
    if (r < -128'sd2147483648) return 32'h8000_0000;
    s = 1'b0;
    return r[31:0];
  endfunction

  task automatic do_frame(input logic m, input logic [31:0] x0, input logic [31:0] x1,
                          input logic [31:0] g, input logic [31:0] o, input logic [31:0] ig,
                          input int hold);
    exp_t e, got_e;
    logic s0, s1;
    int lat;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; mode = m; in_data = {x1, x0};
    gain = g; offset = o; inv_gain = ig; out_ready = 1'b0;
    e.d = {model(m, x1, g, o, ig, s1), model(m, x0, g, o, ig, s0)};
    e.s = s0 | s1;
    sb.push_back(e);
    @(posedge clk); #1;
    // scramble inputs to prove the frame was captured at accept
    in_valid = 1'b0; mode = ~m; in_data = {$urandom, $urandom};
    gain = $urandom; offset = $urandom; inv_gain = $urandom;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 5);
    got_e = sb.pop_front();
    check("out_data", out_data, got_e.d);
    check("sat", sat, got_e.s);
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold", {out_valid, in_ready, sat, out_data}, {1'b1, 1'b0, got_e.s, got_e.d});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("release", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0;
    gain = '0; offset = '0; inv_gain = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_state", {out_valid, in_ready, sat, out_data}, {1'b0, 1'b1, 1'b0, 64'h0});

    do_frame(1'b0, 32'h0002_0000, 32'h0001_0000, 32'h0001_8000, 32'h0000_8000, 32'h0, 10);
    do_frame(1'b1, 32'h0003_8000, 32'h0000_8000, 32'h0, 32'h0000_8000, 32'h0000_8000, 0);
    do_frame(1'b0, 32'h7FFF_0000, 32'h8000_0000, 32'h0002_0000, 32'h0, 32'h0, 2);
    do_frame(1'b0, 32'h0000_0001, 32'h0000_0003, 32'h0000_8000, 32'h0, 32'h0, 0);
    do_frame(1'b0, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, 32'h0, 1);
    do_frame(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    for (int k = 0; k < 6; k++)
      do_frame(k[0], $urandom, $urandom, $urandom, $urandom, $urandom, k % 3);

    // reset while channel 1 is in MUL discards the frame
    @(negedge clk);
    in_valid = 1'b1; mode = 1'b0; in_data = {32'h0001_0000, 32'h0001_0000};
    gain = 32'h0001_0000; offset = 32'h0; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("mid_reset", {out_valid, in_ready, sat, out_data}, {1'b0, 1'b1, 1'b0, 64'h0});
    repeat (8) @(posedge clk);
    #1 check("no_partial", {out_valid, out_data}, {1'b0, 64'h0});

    do_frame(1'b0, 32'h0002_0000, 32'hFFFF_8000, 32'h0001_8000, 32'h0000_8000, 32'h0, 3);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
